// File: rtl/timer_loader.sv
// Keypad-to-timer loader: buffers up to three BCD digits, shifts them serially into a
// countdown timer and enables it. Define TIMER_LOADER_VALIDATE_EN to reject starts with tens > 5.
module timer_loader (
  input  logic       clk,
  input  logic       clr,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       start,
  input  logic       cancel,
  input  logic       timer_zero,
  output logic [3:0] CNT_out,
  output logic       loadn,
  output logic       en,
  output logic [1:0] digits,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    RUN  = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] b_min_q, b_min_d;
  logic [3:0] b_ten_q, b_ten_d;
  logic [3:0] b_one_q, b_one_d;
  logic [1:0] digits_q, digits_d;
  logic [1:0] send_cnt_q, send_cnt_d;
  logic [3:0] cnt_out_q, cnt_out_d;
  logic       loadn_q, loadn_d;
  logic       en_q, en_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       err_q, err_d;

  // Buffer as it stands after this cycle's key; a same-cycle start is judged against it.
  logic [3:0] k_min, k_ten, k_one;
  logic [1:0] k_digits;
  logic       key_err;
  logic       start_ok;

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path can infer a latch.
    state_d    = state_q;
    b_min_d    = b_min_q;
    b_ten_d    = b_ten_q;
    b_one_d    = b_one_q;
    digits_d   = digits_q;
    send_cnt_d = send_cnt_q;
    cnt_out_d  = 4'd0;
    loadn_d    = 1'b1;
    en_d       = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    k_min      = b_min_q;
    k_ten      = b_ten_q;
    k_one      = b_one_q;
    k_digits   = digits_q;
    key_err    = 1'b0;
    start_ok   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (key_valid) begin
          if (key_digit > 4'd9) begin
            key_err = 1'b1;
          end else if (digits_q != 2'd3) begin
            k_min    = b_ten_q;
            k_ten    = b_one_q;
            k_one    = key_digit;
            k_digits = digits_q + 2'd1;
          end
        end
        start_ok = start && (k_digits != 2'd0) && ((k_min | k_ten | k_one) != 4'd0);
`ifdef TIMER_LOADER_VALIDATE_EN
        if (k_ten > 4'd5) start_ok = 1'b0;
`endif
        b_min_d  = k_min;
        b_ten_d  = k_ten;
        b_one_d  = k_one;
        digits_d = k_digits;
        err_d    = key_err || (start && !start_ok);
        if (start_ok) begin
          state_d    = SEND;
          send_cnt_d = 2'd0;
        end
      end

      SEND: begin
        send_cnt_d = send_cnt_q + 2'd1;
        // Oldest digit first: the timer shifts ones -> tens -> mins.
        unique case (send_cnt_q)
          2'd0: begin loadn_d = 1'b0; cnt_out_d = b_min_q; end
          2'd1: begin loadn_d = 1'b0; cnt_out_d = b_ten_q; end
          2'd2: begin loadn_d = 1'b0; cnt_out_d = b_one_q; end
          default: begin
            state_d  = RUN;
            en_d     = 1'b1;
            b_min_d  = 4'd0;
            b_ten_d  = 4'd0;
            b_one_d  = 4'd0;
            digits_d = 2'd0;
          end
        endcase
      end

      RUN: begin
        if (timer_zero) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          en_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    if (cancel) begin
      state_d    = IDLE;
      b_min_d    = 4'd0;
      b_ten_d    = 4'd0;
      b_one_d    = 4'd0;
      digits_d   = 2'd0;
      send_cnt_d = 2'd0;
      cnt_out_d  = 4'd0;
      loadn_d    = 1'b1;
      en_d       = 1'b0;
      done_d     = 1'b0;
      err_d      = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge values.
    if (clr) begin
      state_q    <= IDLE;
      b_min_q    <= 4'd0;
      b_ten_q    <= 4'd0;
      b_one_q    <= 4'd0;
      digits_q   <= 2'd0;
      send_cnt_q <= 2'd0;
      cnt_out_q  <= 4'd0;
      loadn_q    <= 1'b1;
      en_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      b_min_q    <= b_min_d;
      b_ten_q    <= b_ten_d;
      b_one_q    <= b_one_d;
      digits_q   <= digits_d;
      send_cnt_q <= send_cnt_d;
      cnt_out_q  <= cnt_out_d;
      loadn_q    <= loadn_d;
      en_q       <= en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign CNT_out = cnt_out_q;
  assign loadn   = loadn_q;
  assign en      = en_q;
  assign digits  = digits_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule

// File: tb/tb_timer_loader.sv
// Cycle-level bench for timer_loader: a vector table plus hand-written corner sequences,
// with expected outputs queued at drive time and compared after each clock edge.
module tb_timer_loader;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       key_valid = 1'b0;
  logic [3:0] key_digit = 4'd0;
  logic       start = 1'b0;
  logic       cancel = 1'b0;
  logic       timer_zero = 1'b0;
  logic [3:0] CNT_out;
  logic       loadn, en, busy, done, err;
  logic [1:0] digits;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  timer_loader dut (
    .clk       (clk),
    .clr       (clr),
    .key_valid (key_valid),
    .key_digit (key_digit),
    .start     (start),
    .cancel    (cancel),
    .timer_zero(timer_zero),
    .CNT_out   (CNT_out),
    .loadn     (loadn),
    .en        (en),
    .digits    (digits),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  typedef struct {
    logic       clr, kv;
    logic [3:0] kd;
    logic       st, cn, tz;
    logic [3:0] cnt;
    logic       ld, en;
    logic [1:0] dg;
    logic       bz, dn, er;
  } vec_t;

  typedef struct {
    int         idx;
    logic [3:0] cnt;
    logic       ld, en;
    logic [1:0] dg;
    logic       bz, dn, er;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   step_no = 0;

  function automatic vec_t mk(input logic c, kv, input logic [3:0] kd, input logic st, cn, tz,
                              input logic [3:0] cnt, input logic ld, en, input logic [1:0] dg,
                              input logic bz, dn, er);
    vec_t v;
    v.clr = c;  v.kv = kv; v.kd = kd; v.st = st; v.cn = cn; v.tz = tz;
    v.cnt = cnt; v.ld = ld; v.en = en; v.dg = dg; v.bz = bz; v.dn = dn; v.er = er;
    return v;
  endfunction

  task automatic add(input logic c, kv, input logic [3:0] kd, input logic st, cn, tz,
                     input logic [3:0] cnt, input logic ld, en, input logic [1:0] dg,
                     input logic bz, dn, er);
    vecs.push_back(mk(c, kv, kd, st, cn, tz, cnt, ld, en, dg, bz, dn, er));
  endtask

  task automatic check(input string name, input int idx, input logic [3:0] act, exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL step%0d %s: got %0d expected %0d", idx, name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, then compare after the edge.
  task automatic step(input vec_t v);
    exp_t e;
    @(negedge clk);
    clr = v.clr; key_valid = v.kv; key_digit = v.kd;
    start = v.st; cancel = v.cn; timer_zero = v.tz;
    e.idx = step_no; e.cnt = v.cnt; e.ld = v.ld; e.en = v.en;
    e.dg = v.dg; e.bz = v.bz; e.dn = v.dn; e.er = v.er;
    sb.push_back(e);
    step_no++;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL scoreboard: got empty queue expected one entry");
    end else begin
      e = sb.pop_front();
      check("CNT_out", e.idx, CNT_out, e.cnt);
      check("loadn",   e.idx, {3'b0, loadn}, {3'b0, e.ld});
      check("en",      e.idx, {3'b0, en},    {3'b0, e.en});
      check("digits",  e.idx, {2'b0, digits}, {2'b0, e.dg});
      check("busy",    e.idx, {3'b0, busy},  {3'b0, e.bz});
      check("done",    e.idx, {3'b0, done},  {3'b0, e.dn});
      check("err",     e.idx, {3'b0, err},   {3'b0, e.er});
    end
  endtask

  task automatic go(input logic c, kv, input logic [3:0] kd, input logic st, cn, tz,
                    input logic [3:0] cnt, input logic ld, en, input logic [1:0] dg,
                    input logic bz, dn, er);
    step(mk(c, kv, kd, st, cn, tz, cnt, ld, en, dg, bz, dn, er));
  endtask

  initial begin
    //   clr kv kd st cn tz | cnt ld en dg bz dn er
    add(1, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0, 0);   // reset state
    // keys 1,3,0 then start
    add(0, 1, 1, 0, 0, 0,   0, 1, 0, 1, 0, 0, 0);
    add(0, 1, 3, 0, 0, 0,   0, 1, 0, 2, 0, 0, 0);
    add(0, 1, 0, 0, 0, 1,   0, 1, 0, 3, 0, 0, 0);   // timer_zero ignored in IDLE
    add(0, 0, 0, 1, 0, 0,   0, 1, 0, 3, 1, 0, 0);   // start accepted, edge N
    add(0, 1, 9, 1, 0, 1,   1, 0, 0, 3, 1, 0, 0);   // key/start/tz ignored in SEND
    add(0, 0, 0, 0, 0, 0,   3, 0, 0, 3, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0,   0, 0, 0, 3, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0,   0, 1, 1, 0, 1, 0, 0);   // RUN
    add(0, 1, 5, 1, 0, 0,   0, 1, 1, 0, 1, 0, 0);   // key/start ignored in RUN
    add(0, 0, 0, 0, 0, 1,   0, 1, 0, 0, 0, 1, 0);   // zero -> done
    add(0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0, 0);
    // keys 4,5 then start -> 0,4,5
    add(0, 1, 4, 0, 0, 0,   0, 1, 0, 1, 0, 0, 0);
    add(0, 1, 5, 0, 0, 0,   0, 1, 0, 2, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0,   0, 1, 0, 2, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0,   0, 0, 0, 2, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0,   4, 0, 0, 2, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0,   5, 0, 0, 2, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0,   0, 1, 1, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1,   0, 1, 0, 0, 0, 1, 0);
    // bad key, then overflow of the buffer
    add(0, 1, 12, 0, 0, 0,  0, 1, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0, 0);
    add(0, 1, 1, 0, 0, 0,   0, 1, 0, 1, 0, 0, 0);
    add(0, 1, 2, 0, 0, 0,   0, 1, 0, 2, 0, 0, 0);
    add(0, 1, 3, 0, 0, 0,   0, 1, 0, 3, 0, 0, 0);
    add(0, 1, 4, 0, 0, 0,   0, 1, 0, 3, 0, 0, 0);   // dropped, no err
    add(0, 0, 0, 1, 0, 0,   0, 1, 0, 3, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0,   1, 0, 0, 3, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0,   2, 0, 0, 3, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0,   3, 0, 0, 3, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0,   0, 1, 1, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1,   0, 1, 0, 0, 0, 1, 0);
    // rejected starts: empty buffer, all-zero buffer, key+start still all zero
    add(0, 0, 0, 1, 0, 0,   0, 1, 0, 0, 0, 0, 1);
    add(0, 1, 0, 0, 0, 0,   0, 1, 0, 1, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0,   0, 1, 0, 2, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0,   0, 1, 0, 2, 0, 0, 1);   // buffer kept
    add(0, 1, 0, 1, 0, 0,   0, 1, 0, 3, 0, 0, 1);
    add(0, 0, 0, 0, 1, 0,   0, 1, 0, 0, 0, 0, 0);   // cancel clears
    // key and start together: start sees the new digit
    add(0, 1, 0, 0, 0, 0,   0, 1, 0, 1, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0,   0, 1, 0, 2, 0, 0, 0);
    add(0, 1, 5, 1, 0, 0,   0, 1, 0, 3, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0,   0, 0, 0, 3, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0,   0, 0, 0, 3, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0,   5, 0, 0, 3, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0,   0, 1, 1, 0, 1, 0, 0);
    add(0, 0, 0, 0, 1, 1,   0, 1, 0, 0, 0, 0, 0);   // cancel beats timer_zero: no done
    // keys 1,7,0 then start: tens check only when validation is built in
    add(0, 1, 1, 0, 0, 0,   0, 1, 0, 1, 0, 0, 0);
    add(0, 1, 7, 0, 0, 0,   0, 1, 0, 2, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0,   0, 1, 0, 3, 0, 0, 0);
`ifdef TIMER_LOADER_VALIDATE_EN
    add(0, 0, 0, 1, 0, 0,   0, 1, 0, 3, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0,   0, 1, 0, 3, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0,   0, 1, 0, 0, 0, 0, 0);
`else
    add(0, 0, 0, 1, 0, 0,   0, 1, 0, 3, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0,   1, 0, 0, 3, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0,   7, 0, 0, 3, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0,   0, 0, 0, 3, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0,   0, 1, 1, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1,   0, 1, 0, 0, 0, 1, 0);
`endif

    for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

    // cancel during the second SEND cycle (first digit on the bus)
    go(0, 1, 2, 0, 0, 0,   0, 1, 0, 1, 0, 0, 0);
    go(0, 1, 3, 0, 0, 0,   0, 1, 0, 2, 0, 0, 0);
    go(0, 0, 0, 1, 0, 0,   0, 1, 0, 2, 1, 0, 0);
    go(0, 0, 0, 0, 0, 0,   0, 0, 0, 2, 1, 0, 0);
    go(0, 1, 4, 1, 1, 0,   0, 1, 0, 0, 0, 0, 0);
    go(0, 0, 0, 1, 0, 0,   0, 1, 0, 0, 0, 0, 1);   // buffer really cleared

    // clr during RUN overrides cancel and keys
    go(0, 1, 8, 0, 0, 0,   0, 1, 0, 1, 0, 0, 0);
    go(0, 0, 0, 1, 0, 0,   0, 1, 0, 1, 1, 0, 0);
    go(0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 1, 0, 0);
    go(0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 1, 0, 0);
    go(0, 0, 0, 0, 0, 0,   8, 0, 0, 1, 1, 0, 0);
    go(0, 0, 0, 0, 0, 0,   0, 1, 1, 0, 1, 0, 0);
    go(1, 1, 3, 1, 1, 1,   0, 1, 0, 0, 0, 0, 0);

    // clr mid-SEND takes effect at the same edge
    go(0, 1, 6, 0, 0, 0,   0, 1, 0, 1, 0, 0, 0);
    go(0, 0, 0, 1, 0, 0,   0, 1, 0, 1, 1, 0, 0);
    go(0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 1, 0, 0);
    go(1, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0, 0);
    go(0, 0, 0, 0, 0, 1,   0, 1, 0, 0, 0, 0, 0);

    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
